// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
//   Serial configuration writer for the CLB array. Hunts the serial stream for
//   the sync byte, then assembles CFG_W-bit words (MSB first), each followed by
//   one even-parity bit. Every good frame is written to the next CLB through
//   the shared `bits_o` bus and a one-hot, single-cycle `wr_en_o` strobe.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      one-cycle pulse, (re)starts a load from any state
//   sdi_i        serial config data
//   sdi_valid_i  qualifies sdi_i, one bit per cycle
//   wr_en_o      one-hot write strobe to CLB[clb_idx], registered
//   bits_o       config word, held until the next good frame completes
//   clb_idx_o    index of the next CLB to be written (saturates at last CLB)
//   busy_o       high while hunting for sync or loading frames
//   done_o       sticky, all NUM_CLB frames written
//   err_o        sticky, a frame failed its parity check
// -----------------------------------------------------------------------------
module clb_cfg_loader #(
  parameter int          NUM_CLB = 16,
  parameter int          CFG_W   = 23,
  parameter logic [7:0]  SYNC    = 8'hA5,
  localparam int         IDX_W   = $clog2(NUM_CLB)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               sdi_i,
  input  logic               sdi_valid_i,
  output logic [NUM_CLB-1:0] wr_en_o,
  output logic [CFG_W-1:0]   bits_o,
  output logic [IDX_W-1:0]   clb_idx_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  // Counter spans 0..CFG_W: values below CFG_W are data bits, CFG_W is parity.
  localparam int CNT_W = $clog2(CFG_W + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC_HUNT = 3'd1,
    LOAD      = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } state_e;

  state_e             state_q;
  logic [7:0]         win_q;
  logic [CFG_W-1:0]   sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CFG_W-1:0]   bits_q;
  logic [NUM_CLB-1:0] wr_en_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  // Next-value helpers for the shifters and frame completion.
  logic [7:0]         win_d;
  logic [CFG_W-1:0]   sr_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [NUM_CLB-1:0] hot_d;
  logic               par_ok;
  logic               par_bit;
  logic               last_clb;

  always_comb begin
    win_d    = {win_q[6:0], sdi_i};
    sr_d     = {sr_q[CFG_W-2:0], sdi_i};
    cnt_d    = cnt_q + 1'b1;
    hot_d    = NUM_CLB'(1) << idx_q;
    // Parity bit must equal the XOR of the data bits (even parity over all).
    par_ok   = (sdi_i == ^sr_q);
    par_bit  = (cnt_q == CNT_W'(CFG_W));
    last_clb = (idx_q == IDX_W'(NUM_CLB - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      bits_q  <= '0;
      wr_en_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Strobe is a single-cycle pulse; a strobe registered on the previous
      // edge has already been seen by the fabric, so start never cancels it.
      wr_en_q <= '0;
      if (start_i) begin
        state_q <= SYNC_HUNT;
        win_q   <= '0;
        sr_q    <= '0;
        cnt_q   <= '0;
        idx_q   <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;

          SYNC_HUNT: begin
            if (sdi_valid_i) begin
              win_q <= win_d;
              // Match on the updated window so an overlapping sync locks
              // as soon as its last bit arrives.
              if (win_d == SYNC) begin
                state_q <= LOAD;
                cnt_q   <= '0;
              end
            end
          end

          LOAD: begin
            if (sdi_valid_i) begin
              if (par_bit) begin
                cnt_q <= '0;
                if (par_ok) begin
                  bits_q  <= sr_q;
                  wr_en_q <= hot_d;
                  if (last_clb) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                  end else begin
                    idx_q <= idx_q + 1'b1;
                  end
                end else begin
                  state_q <= ERROR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                end
              end else begin
                sr_q  <= sr_d;
                cnt_q <= cnt_d;
              end
            end
          end

          DONE, ERROR: ;

          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign bits_o    = bits_q;
  assign clb_idx_o = idx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_clb_cfg_loader
//   Directed bench for clb_cfg_loader with NUM_CLB=4. The driver pushes the
//   expected strobe (one-hot, word, cycle) whenever it sends a good frame; a
//   monitor on the falling edge pops and compares every strobe it sees.
// -----------------------------------------------------------------------------
module tb_clb_cfg_loader;

  localparam int NCLB = 4;
  localparam int CW   = 23;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            sdi;
  logic            sdi_valid;
  logic [NCLB-1:0] wr_en;
  logic [CW-1:0]   bits;
  logic [1:0]      clb_idx;
  logic            busy;
  logic            done;
  logic            err;

  clb_cfg_loader #(.NUM_CLB(NCLB), .CFG_W(CW), .SYNC(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .sdi_i      (sdi),
    .sdi_valid_i(sdi_valid),
    .wr_en_o    (wr_en),
    .bits_o     (bits),
    .clb_idx_o  (clb_idx),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NCLB-1:0] wr;
    logic [CW-1:0]   word;
    int              cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_idx = 0;

  // Nominal frame table with hand-computed parity bits.
  logic [CW-1:0] W [4] = '{23'h7FFFFF, 23'h000000, 23'h012345, 23'h400001};
  logic          P [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en !== '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got wr_en=%b bits=%h expected no strobe", wr_en, bits);
      end else begin
        e = q.pop_front();
        check("strobe_wr_en", 32'(wr_en), 32'(e.wr));
        check("strobe_bits", 32'(bits), 32'(e.word));
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  // One bit, preceded by 0..gap idle cycles; inputs change #1 after the edge.
  task automatic send_bit(input logic b, input int gap);
    int g;
    g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
    sdi_valid = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    sdi       = b;
    sdi_valid = 1'b1;
    @(posedge clk);
    #1;
    sdi_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  // Good frames schedule a strobe visible in the cycle right after parity.
  task automatic send_frame(input logic [CW-1:0] w, input logic p, input int gap, input bit good);
    exp_t x;
    for (int i = CW - 1; i >= 0; i--) send_bit(w[i], gap);
    send_bit(p, gap);
    if (good) begin
      x.wr   = NCLB'(1) << exp_idx;
      x.word = w;
      x.cyc  = cyc;
      q.push_back(x);
      if (exp_idx < NCLB - 1) exp_idx++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    exp_idx = 0;
  endtask

  initial begin
    logic [10:0] pre;
    rst_n = 1'b0; start = 1'b0; sdi = 1'b0; sdi_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_bits", 32'(bits), 0);
    check("rst_idx", 32'(clb_idx), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal load, continuous sdi_valid.
    pulse_start();
    check("nom_busy_after_start", 32'(busy), 1);
    send_byte(8'hA5, 0);
    for (int f = 0; f < 4; f++) send_frame(W[f], P[f], 0, 1'b1);
    check("nom_done", 32'(done), 1);
    check("nom_busy", 32'(busy), 0);
    check("nom_err", 32'(err), 0);
    check("nom_idx_sat", 32'(clb_idx), 3);
    check("nom_bits_last", 32'(bits), 32'h400001);
    // Stream after DONE is ignored.
    send_frame(23'h555555, 1'b0, 0, 1'b0);
    check("done_hold", 32'(done), 1);
    check("done_bits_hold", 32'(bits), 32'h400001);

    // Parity error on frame 1.
    pulse_start();
    check("restart_done_clr", 32'(done), 0);
    check("restart_idx", 32'(clb_idx), 0);
    send_byte(8'hA5, 0);
    send_frame(W[0], P[0], 0, 1'b1);
    send_frame(W[1], ~P[1], 0, 1'b0);
    check("perr_err", 32'(err), 1);
    check("perr_busy", 32'(busy), 0);
    check("perr_bits_kept", 32'(bits), 32'(W[0]));
    check("perr_idx", 32'(clb_idx), 1);
    send_frame(W[2], P[2], 0, 1'b0);
    check("perr_err_hold", 32'(err), 1);
    pulse_start();
    check("perr_start_err_clr", 32'(err), 0);
    check("perr_start_busy", 32'(busy), 1);

    // Same load with random 0-5 idle cycles between bits.
    send_byte(8'hA5, 5);
    for (int f = 0; f < 4; f++) send_frame(W[f], P[f], 5, 1'b1);
    check("gap_done", 32'(done), 1);
    check("gap_bits", 32'(bits), 32'h400001);

    // Overlapping sync prefix, then start mid-LOAD after frame 1.
    pulse_start();
    pre = 11'b101_10100101;
    for (int i = 10; i >= 0; i--) send_bit(pre[i], 0);
    check("ovl_busy", 32'(busy), 1);
    send_frame(23'h012345, 1'b1, 0, 1'b1);
    send_frame(23'h7FFFFF, 1'b1, 0, 1'b1);
    check("ovl_idx2", 32'(clb_idx), 2);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    pulse_start();
    check("mid_start_idx", 32'(clb_idx), 0);
    send_byte(8'hA5, 0);
    for (int f = 0; f < 3; f++) send_frame(W[f], P[f], 0, 1'b1);
    check("mid_not_done", 32'(done), 0);
    check("mid_idx3", 32'(clb_idx), 3);
    send_frame(W[3], P[3], 0, 1'b1);
    check("mid_done", 32'(done), 1);

    // Asynchronous reset 10 bits into frame 2.
    pulse_start();
    send_byte(8'hA5, 0);
    send_frame(23'h7FFFFF, 1'b1, 0, 1'b1);
    send_frame(23'h012345, 1'b1, 0, 1'b1);
    for (int i = 22; i > 12; i--) send_bit(W[3][i], 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bits", 32'(bits), 0);
    check("arst_idx", 32'(clb_idx), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_err", 32'(err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) send_bit(i[0], 0);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_idx", 32'(clb_idx), 0);
    check("post_rst_bits", 32'(bits), 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
